// File: rtl/target_pkg.sv
// Shared constants and FSM state type for the snake target picker.
// Latency: n/a (package only).
// Backpressure: n/a.
package target_pkg;

   // Default coordinate widths for a 160x120 playfield.
   localparam int DEF_X_W = 8;
   localparam int DEF_Y_W = 7;

   // Default Fibonacci tap masks (maximal-length for 8 and 7 bits).
   localparam logic [7:0] DEF_X_TAPS = 8'hB8;
   localparam logic [6:0] DEF_Y_TAPS = 7'h60;

   // Default playfield limits: legal coordinates are 0..LIMIT-1.
   localparam int DEF_X_LIMIT = 160;
   localparam int DEF_Y_LIMIT = 120;

   // Default LFSR seeds; these also form the target held after reset.
   localparam int DEF_SEED_X = 80;
   localparam int DEF_SEED_Y = 60;

   // Default number of candidate draws before the fallback target is used.
   localparam int DEF_MAX_TRIES = 16;

   // IDLE: target valid and stable.  SEARCH: drawing candidates.
   typedef enum logic {
      IDLE   = 1'b0,
      SEARCH = 1'b1
   } state_t;

endpackage

// File: rtl/lfsr_core.sv
// Free-running Fibonacci XNOR LFSR with optional seed load (TARGET_PICKER_SEED_LOAD_EN).
// Latency: one step per clock; a load takes effect on the next edge.
// Backpressure: none, the register steps every cycle.
module lfsr_core
   import target_pkg::*;
#(
   parameter int           W    = 8,
   parameter logic [W-1:0] TAPS = '0,
   parameter logic [W-1:0] SEED = '0
)(
   input  logic         i_clk,
   input  logic         i_rst_n,
`ifdef TARGET_PICKER_SEED_LOAD_EN
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
`endif
   output logic [W-1:0] o_lfsr
);

   logic [W-1:0] r_lfsr;
   logic [W-1:0] w_next;

   // Next value: shift left with the XNOR of the tapped bits as the new LSB;
   // a load overrides the step, and all-ones (the XNOR lock-up) falls back to SEED.
   always_comb begin
      w_next = {r_lfsr[W-2:0], ~^(r_lfsr & TAPS)};
`ifdef TARGET_PICKER_SEED_LOAD_EN
      if (i_load) begin
         w_next = (&i_load_val) ? SEED : i_load_val;
      end
`endif
   end

   // LFSR state register, forced to SEED while reset is held.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_lfsr <= SEED;
      end else begin
         r_lfsr <= w_next;
      end
   end

   assign o_lfsr = r_lfsr;

   // An all-ones seed would lock the XNOR LFSR; a 1-bit LFSR cannot shift.
   if (SEED == {W{1'b1}}) begin : g_bad_seed
      $error("lfsr_core: SEED must not be all-ones");
   end
   if (W < 2) begin : g_bad_width
      $error("lfsr_core: W must be at least 2");
   end

endmodule

// File: rtl/target_picker.sv
// Picks a random legal target cell distinct from the current target and the snake head.
// Latency: 1..MAX_TRIES cycles from the SEARCH entry to VALID; fallback target after MAX_TRIES rejects.
// Backpressure: none; TARGET_REACHED is dropped while BUSY. Optional seed load: TARGET_PICKER_SEED_LOAD_EN.
module target_picker
   import target_pkg::*;
#(
   parameter int             X_W       = DEF_X_W,
   parameter int             Y_W       = DEF_Y_W,
   parameter logic [X_W-1:0] X_TAPS    = X_W'(DEF_X_TAPS),
   parameter logic [Y_W-1:0] Y_TAPS    = Y_W'(DEF_Y_TAPS),
   parameter int             X_LIMIT   = DEF_X_LIMIT,
   parameter int             Y_LIMIT   = DEF_Y_LIMIT,
   parameter int             SEED_X    = DEF_SEED_X,
   parameter int             SEED_Y    = DEF_SEED_Y,
   parameter int             MAX_TRIES = DEF_MAX_TRIES
)(
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic           i_target_reached,
   input  logic [X_W-1:0] i_head_x,
   input  logic [Y_W-1:0] i_head_y,
`ifdef TARGET_PICKER_SEED_LOAD_EN
   input  logic           i_seed_load,
   input  logic [X_W-1:0] i_seed_x_in,
   input  logic [Y_W-1:0] i_seed_y_in,
`endif
   output logic [X_W-1:0] o_target_x,
   output logic [Y_W-1:0] o_target_y,
   output logic           o_valid,
   output logic           o_busy
);

   // Try counter holds 0..MAX_TRIES-1 and is sized so it can never wrap.
   localparam int TRY_W = $clog2(MAX_TRIES + 1);

   // Limits widened by one bit so a limit of 2**W is representable.
   localparam logic [X_W:0]       X_LIM_V  = (X_W + 1)'(X_LIMIT);
   localparam logic [Y_W:0]       Y_LIM_V  = (Y_W + 1)'(Y_LIMIT);
   localparam logic [X_W-1:0]     X_LAST   = X_W'(X_LIMIT - 1);
   localparam logic [Y_W-1:0]     Y_LAST   = Y_W'(Y_LIMIT - 1);
   localparam logic [X_W-1:0]     SEED_XV  = X_W'(SEED_X);
   localparam logic [Y_W-1:0]     SEED_YV  = Y_W'(SEED_Y);
   localparam logic [TRY_W-1:0]   TRY_LAST = TRY_W'(MAX_TRIES - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [X_W-1:0]   r_target_x;
   logic [Y_W-1:0]   r_target_y;
   logic [TRY_W-1:0] r_tries;

   logic [X_W-1:0]   w_lfsr_x;
   logic [Y_W-1:0]   w_lfsr_y;
   logic [X_W-1:0]   w_fb_x;
   logic [Y_W-1:0]   w_fb_y;
   logic             w_in_range;
   logic             w_hit_target;
   logic             w_hit_head;
   logic             w_accept;
   logic             w_last_try;

   // ------------------------------------------------------------------
   // Random sources: both LFSRs run in every state, the FSM only samples them.
   // ------------------------------------------------------------------
   lfsr_core #(
      .W    (X_W),
      .TAPS (X_TAPS),
      .SEED (SEED_XV)
   ) u_lfsr_x (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
`ifdef TARGET_PICKER_SEED_LOAD_EN
      .i_load     (i_seed_load),
      .i_load_val (i_seed_x_in),
`endif
      .o_lfsr     (w_lfsr_x)
   );

   lfsr_core #(
      .W    (Y_W),
      .TAPS (Y_TAPS),
      .SEED (SEED_YV)
   ) u_lfsr_y (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
`ifdef TARGET_PICKER_SEED_LOAD_EN
      .i_load     (i_seed_load),
      .i_load_val (i_seed_y_in),
`endif
      .o_lfsr     (w_lfsr_y)
   );

   // ------------------------------------------------------------------
   // Candidate qualification: in range, not the current target, not the head.
   // ------------------------------------------------------------------
   assign w_in_range   = ({1'b0, w_lfsr_x} < X_LIM_V) && ({1'b0, w_lfsr_y} < Y_LIM_V);
   assign w_hit_target = (w_lfsr_x == r_target_x) && (w_lfsr_y == r_target_y);
   assign w_hit_head   = (w_lfsr_x == i_head_x)   && (w_lfsr_y == i_head_y);
   assign w_accept     = w_in_range && !w_hit_target && !w_hit_head;
   assign w_last_try   = (r_tries == TRY_LAST);

   // Fallback is the diagonal neighbour with wrap; it is deliberately not
   // checked against the head so the search always terminates.
   assign w_fb_x = (r_target_x == X_LAST) ? '0 : r_target_x + X_W'(1);
   assign w_fb_y = (r_target_y == Y_LAST) ? '0 : r_target_y + Y_W'(1);

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------

   // State register; reset always lands in IDLE, aborting any search.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state: a request starts a search; acceptance or the last try ends it.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (i_target_reached) begin
               w_state_nxt = SEARCH;
            end
         end
         SEARCH: begin
            if (w_accept || w_last_try) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Outputs decoded from state only, so VALID is high throughout reset.
   always_comb begin
      o_valid = 1'b0;
      o_busy  = 1'b0;
      case (r_state)
         IDLE:    o_valid = 1'b1;
         SEARCH:  o_busy  = 1'b1;
         default: o_valid = 1'b0;
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath: target and try counter. The target only changes on the edge
   // that leaves SEARCH, so it is stable for the whole search.
   // ------------------------------------------------------------------

   // Target / try-counter update.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_target_x <= SEED_XV;
         r_target_y <= SEED_YV;
         r_tries    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_target_reached) begin
                  r_tries <= '0;
               end
            end
            SEARCH: begin
               if (w_accept) begin
                  r_target_x <= w_lfsr_x;
                  r_target_y <= w_lfsr_y;
               end else if (w_last_try) begin
                  r_target_x <= w_fb_x;
                  r_target_y <= w_fb_y;
               end else begin
                  r_tries <= r_tries + TRY_W'(1);
               end
            end
            default: begin
               r_tries <= '0;
            end
         endcase
      end
   end

   assign o_target_x = r_target_x;
   assign o_target_y = r_target_y;

   // ------------------------------------------------------------------
   // Elaboration-time parameter sanity.
   // ------------------------------------------------------------------
   if (SEED_X < 0 || SEED_X >= X_LIMIT) begin : g_bad_seed_x
      $error("target_picker: SEED_X outside 0..X_LIMIT-1");
   end
   if (SEED_Y < 0 || SEED_Y >= Y_LIMIT) begin : g_bad_seed_y
      $error("target_picker: SEED_Y outside 0..Y_LIMIT-1");
   end
   if (SEED_XV == {X_W{1'b1}}) begin : g_lock_seed_x
      $error("target_picker: SEED_X is the all-ones lock-up value");
   end
   if (SEED_YV == {Y_W{1'b1}}) begin : g_lock_seed_y
      $error("target_picker: SEED_Y is the all-ones lock-up value");
   end
   if (X_LIMIT < 2 || X_LIMIT > (1 << X_W)) begin : g_bad_x_limit
      $error("target_picker: X_LIMIT must be in 2..2**X_W");
   end
   if (Y_LIMIT < 2 || Y_LIMIT > (1 << Y_W)) begin : g_bad_y_limit
      $error("target_picker: Y_LIMIT must be in 2..2**Y_W");
   end
   if (MAX_TRIES < 1) begin : g_bad_tries
      $error("target_picker: MAX_TRIES must be at least 1");
   end

endmodule

// File: tb/tb_target_picker.sv
// Directed self-checking bench for target_picker (default build and TARGET_PICKER_SEED_LOAD_EN).
// Latency: expected search latency comes from an LFSR reference model.
// Backpressure: n/a.
module tb_target_picker;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req;
   logic [7:0] head_x;
   logic [6:0] head_y;
   wire  [7:0] tx;
   wire  [6:0] ty;
   wire        valid;
   wire        busy;

   logic       req2;
   logic [7:0] head2_x;
   logic [6:0] head2_y;
   wire  [7:0] tx2;
   wire  [6:0] ty2;
   wire        valid2;
   wire        busy2;

`ifdef TARGET_PICKER_SEED_LOAD_EN
   logic       seed_load;
   logic [7:0] seed_x_in;
   logic [6:0] seed_y_in;
   logic       seed2_load;
   logic [7:0] seed2_x_in;
   logic [6:0] seed2_y_in;
`endif

   int checks = 0;
   int errors = 0;

   // Reference LFSR models and the target the bench expects the DUT to hold.
   logic [7:0] m_x;
   logic [6:0] m_y;
   logic [7:0] m2_x;
   logic [6:0] m2_y;
   logic [7:0] cur_tx;
   logic [6:0] cur_ty;

   always #5 clk = ~clk;

   target_picker dut (
      .i_clk            (clk),
      .i_rst_n          (rst_n),
      .i_target_reached (req),
      .i_head_x         (head_x),
      .i_head_y         (head_y),
`ifdef TARGET_PICKER_SEED_LOAD_EN
      .i_seed_load      (seed_load),
      .i_seed_x_in      (seed_x_in),
      .i_seed_y_in      (seed_y_in),
`endif
      .o_target_x       (tx),
      .o_target_y       (ty),
      .o_valid          (valid),
      .o_busy           (busy)
   );

   // Tiny playfield, single try, zero seeds: exercises the fallback path.
   target_picker #(
      .X_LIMIT   (2),
      .Y_LIMIT   (2),
      .MAX_TRIES (1),
      .SEED_X    (0),
      .SEED_Y    (0)
   ) dut2 (
      .i_clk            (clk),
      .i_rst_n          (rst_n),
      .i_target_reached (req2),
      .i_head_x         (head2_x),
      .i_head_y         (head2_y),
`ifdef TARGET_PICKER_SEED_LOAD_EN
      .i_seed_load      (seed2_load),
      .i_seed_x_in      (seed2_x_in),
      .i_seed_y_in      (seed2_y_in),
`endif
      .o_target_x       (tx2),
      .o_target_y       (ty2),
      .o_valid          (valid2),
      .o_busy           (busy2)
   );

   function automatic logic [7:0] step_x(input logic [7:0] v);
      return {v[6:0], ~^(v & 8'hB8)};
   endfunction

   function automatic logic [6:0] step_y(input logic [6:0] v);
      return {v[5:0], ~^(v & 7'h60)};
   endfunction

   // Reference LFSR sequence from the seeds, with the optional seed load.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_x  <= 8'd80;
         m_y  <= 7'd60;
         m2_x <= 8'd0;
         m2_y <= 7'd0;
      end else begin
`ifdef TARGET_PICKER_SEED_LOAD_EN
         if (seed_load) begin
            m_x <= (seed_x_in == 8'hFF) ? 8'd80 : seed_x_in;
            m_y <= (seed_y_in == 7'h7F) ? 7'd60 : seed_y_in;
         end else
`endif
         begin
            m_x <= step_x(m_x);
            m_y <= step_y(m_y);
         end
         m2_x <= step_x(m2_x);
         m2_y <= step_y(m2_y);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Predicts the search outcome from the candidate seen in the first SEARCH cycle.
   task automatic predict(input logic [7:0] cx0, input logic [6:0] cy0,
                          input logic [7:0] tx0, input logic [6:0] ty0,
                          input logic [7:0] hx,  input logic [6:0] hy,
                          output logic [7:0] ex, output logic [6:0] ey, output int lat);
      logic [7:0] cx;
      logic [6:0] cy;
      cx = cx0;
      cy = cy0;
      for (int k = 0; k < 16; k++) begin
         if (cx < 8'd160 && cy < 7'd120 && !(cx == tx0 && cy == ty0) && !(cx == hx && cy == hy)) begin
            ex  = cx;
            ey  = cy;
            lat = k + 1;
            return;
         end
         cx = step_x(cx);
         cy = step_y(cy);
      end
      ex  = (tx0 == 8'd159) ? 8'd0 : tx0 + 8'd1;
      ey  = (ty0 == 7'd119) ? 7'd0 : ty0 + 7'd1;
      lat = 16;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(); tick(); tick();
      checks++; if (tx !== 8'd80 || ty !== 7'd60) begin errors++; $display("FAIL reset_target: got (%0d,%0d) want (80,60)", tx, ty); end
      checks++; if (valid !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_flags: got valid=%b busy=%b want 1/0", valid, busy); end
      checks++; if (dut.w_lfsr_x !== 8'd80 || dut.w_lfsr_y !== 7'd60) begin errors++; $display("FAIL reset_lfsr: got (%0d,%0d) want (80,60)", dut.w_lfsr_x, dut.w_lfsr_y); end
      checks++; if (tx2 !== 8'd0 || ty2 !== 7'd0 || valid2 !== 1'b1) begin errors++; $display("FAIL reset_dut2: got (%0d,%0d) valid=%b want (0,0) 1", tx2, ty2, valid2); end
      rst_n  = 1'b1;
      cur_tx = 8'd80;
      cur_ty = 7'd60;
      tick();
      checks++; if (dut.w_lfsr_x !== 8'd160 || dut.w_lfsr_y !== 7'd120) begin errors++; $display("FAIL lfsr_step1: got (%0d,%0d) want (160,120)", dut.w_lfsr_x, dut.w_lfsr_y); end
      tick();
      checks++; if (dut.w_lfsr_x !== 8'd65 || dut.w_lfsr_y !== 7'd113) begin errors++; $display("FAIL lfsr_step2: got (%0d,%0d) want (65,113)", dut.w_lfsr_x, dut.w_lfsr_y); end
      for (int i = 0; i < 16; i++) begin
         tick();
         checks++;
         if (dut.w_lfsr_x !== m_x || dut.w_lfsr_y !== m_y) begin
            errors++; $display("FAIL lfsr_seq[%0d]: got (%0d,%0d) want (%0d,%0d)", i, dut.w_lfsr_x, dut.w_lfsr_y, m_x, m_y);
         end
      end
      checks++; if (valid !== 1'b1 || tx !== 8'd80 || ty !== 7'd60) begin errors++; $display("FAIL idle_hold: got (%0d,%0d) valid=%b want (80,60) 1", tx, ty, valid); end
   endtask

   task automatic test_fallback();
      // Candidate is far outside the 2x2 field here, so it must be rejected.
      req2 = 1'b1;
      tick();
      req2 = 1'b0;
      checks++; if (busy2 !== 1'b1 || tx2 !== 8'd0 || ty2 !== 7'd0) begin errors++; $display("FAIL fb_search: got busy=%b (%0d,%0d) want 1 (0,0)", busy2, tx2, ty2); end
      tick();
      checks++; if (tx2 !== 8'd1 || ty2 !== 7'd1 || valid2 !== 1'b1) begin errors++; $display("FAIL fb_target: got (%0d,%0d) valid=%b want (1,1) 1", tx2, ty2, valid2); end
      tick();
      req2 = 1'b1;
      tick();
      req2 = 1'b0;
      tick();
      checks++; if (tx2 !== 8'd0 || ty2 !== 7'd0 || valid2 !== 1'b1) begin errors++; $display("FAIL fb_wrap: got (%0d,%0d) valid=%b want (0,0) 1", tx2, ty2, valid2); end
   endtask

   task automatic test_search();
      logic [7:0] ex;
      logic [6:0] ey;
      int lat;
      int n;
      head_x = 8'd10;
      head_y = 7'd10;
      req = 1'b1;
      tick();
      req = 1'b0;
      checks++; if (busy !== 1'b1 || valid !== 1'b0) begin errors++; $display("FAIL search_busy: got busy=%b valid=%b want 1/0", busy, valid); end
      predict(m_x, m_y, cur_tx, cur_ty, head_x, head_y, ex, ey, lat);
      n = 0;
      do begin
         tick();
         n++;
         if (valid !== 1'b1) begin
            checks++;
            if (tx !== cur_tx || ty !== cur_ty) begin errors++; $display("FAIL search_hold: got (%0d,%0d) want (%0d,%0d)", tx, ty, cur_tx, cur_ty); end
         end
      end while (valid !== 1'b1 && n < 20);
      checks++; if (valid !== 1'b1 || n != lat) begin errors++; $display("FAIL search_latency: got %0d valid=%b want %0d", n, valid, lat); end
      checks++; if (tx !== ex || ty !== ey) begin errors++; $display("FAIL search_target: got (%0d,%0d) want (%0d,%0d)", tx, ty, ex, ey); end
      checks++; if (tx >= 8'd160 || ty >= 7'd120) begin errors++; $display("FAIL search_range: got (%0d,%0d) want below (160,120)", tx, ty); end
      checks++; if ((tx === 8'd80 && ty === 7'd60) || (tx === 8'd10 && ty === 7'd10)) begin errors++; $display("FAIL search_exclude: got (%0d,%0d) want not (80,60) and not (10,10)", tx, ty); end
      cur_tx = ex;
      cur_ty = ey;
   endtask

   task automatic test_head_exclusion();
      logic [7:0] nx, ex;
      logic [6:0] ny, ey;
      int nlat, lat, n;
      req = 1'b1;
      tick();
      req = 1'b0;
      // Put the head exactly on the candidate that would otherwise win.
      predict(m_x, m_y, cur_tx, cur_ty, 8'hFF, 7'h7F, nx, ny, nlat);
      head_x = nx;
      head_y = ny;
      predict(m_x, m_y, cur_tx, cur_ty, head_x, head_y, ex, ey, lat);
      n = 0;
      do begin tick(); n++; end while (valid !== 1'b1 && n < 20);
      checks++; if (valid !== 1'b1 || n != lat) begin errors++; $display("FAIL head_latency: got %0d valid=%b want %0d", n, valid, lat); end
      checks++; if (tx !== ex || ty !== ey) begin errors++; $display("FAIL head_target: got (%0d,%0d) want (%0d,%0d)", tx, ty, ex, ey); end
      if (lat < 16) begin
         checks++;
         if (tx === head_x && ty === head_y) begin errors++; $display("FAIL head_hit: got (%0d,%0d) want not head", tx, ty); end
      end
      cur_tx = ex;
      cur_ty = ey;
      head_x = 8'd10;
      head_y = 7'd10;
   endtask

   task automatic test_back_to_back();
      logic [7:0] ex;
      logic [6:0] ey;
      int lat, n;
      req = 1'b1;
      tick();
      req = 1'b0;
      predict(m_x, m_y, cur_tx, cur_ty, head_x, head_y, ex, ey, lat);
      // Second request lands while the block is searching.
      req = 1'b1;
      tick();
      req = 1'b0;
      n = 1;
      while (valid !== 1'b1 && n < 20) begin tick(); n++; end
      checks++; if (valid !== 1'b1 || n != lat) begin errors++; $display("FAIL b2b_latency: got %0d valid=%b want %0d", n, valid, lat); end
      checks++; if (tx !== ex || ty !== ey) begin errors++; $display("FAIL b2b_target: got (%0d,%0d) want (%0d,%0d)", tx, ty, ex, ey); end
      tick();
      checks++; if (valid !== 1'b1 || busy !== 1'b0 || tx !== ex || ty !== ey) begin errors++; $display("FAIL b2b_single: got valid=%b busy=%b (%0d,%0d) want 1/0 (%0d,%0d)", valid, busy, tx, ty, ex, ey); end
      cur_tx = ex;
      cur_ty = ey;
   endtask

   task automatic test_reset_mid_search();
      req = 1'b1;
      tick();
      req = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy: got %b want 1", busy); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (tx !== 8'd80 || ty !== 7'd60) begin errors++; $display("FAIL midrst_target: got (%0d,%0d) want (80,60)", tx, ty); end
      checks++; if (valid !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL midrst_flags: got valid=%b busy=%b want 1/0", valid, busy); end
      checks++; if (dut.w_lfsr_x !== 8'd80 || dut.w_lfsr_y !== 7'd60) begin errors++; $display("FAIL midrst_lfsr: got (%0d,%0d) want (80,60)", dut.w_lfsr_x, dut.w_lfsr_y); end
      tick(); tick();
      rst_n  = 1'b1;
      cur_tx = 8'd80;
      cur_ty = 7'd60;
      tick();
      checks++; if (valid !== 1'b1 || tx !== 8'd80 || ty !== 7'd60) begin errors++; $display("FAIL midrst_after: got valid=%b (%0d,%0d) want 1 (80,60)", valid, tx, ty); end
      checks++; if (dut.w_lfsr_x !== 8'd160 || dut.w_lfsr_y !== 7'd120) begin errors++; $display("FAIL midrst_restep: got (%0d,%0d) want (160,120)", dut.w_lfsr_x, dut.w_lfsr_y); end
   endtask

`ifdef TARGET_PICKER_SEED_LOAD_EN
   task automatic test_seed_load();
      seed_load = 1'b1;
      seed_x_in = 8'hFF;
      seed_y_in = 7'h7F;
      tick();
      checks++; if (dut.w_lfsr_x !== 8'd80 || dut.w_lfsr_y !== 7'd60) begin errors++; $display("FAIL load_ones: got (%0d,%0d) want (80,60)", dut.w_lfsr_x, dut.w_lfsr_y); end
      seed_x_in = 8'h05;
      seed_y_in = 7'h05;
      tick();
      checks++; if (dut.w_lfsr_x !== 8'd5 || dut.w_lfsr_y !== 7'd5) begin errors++; $display("FAIL load_val: got (%0d,%0d) want (5,5)", dut.w_lfsr_x, dut.w_lfsr_y); end
      seed_load = 1'b0;
      tick();
      checks++; if (dut.w_lfsr_x !== 8'd11 || dut.w_lfsr_y !== 7'd11) begin errors++; $display("FAIL load_step: got (%0d,%0d) want (11,11)", dut.w_lfsr_x, dut.w_lfsr_y); end
      checks++; if (valid !== 1'b1 || tx !== cur_tx || ty !== cur_ty) begin errors++; $display("FAIL load_target: got valid=%b (%0d,%0d) want 1 (%0d,%0d)", valid, tx, ty, cur_tx, cur_ty); end
      // A search right after a load draws from the reloaded sequence.
      test_search();
   endtask
`endif

   initial begin
      rst_n   = 1'b0;
      req     = 1'b0;
      head_x  = 8'd10;
      head_y  = 7'd10;
      req2    = 1'b0;
      head2_x = 8'd1;
      head2_y = 7'd0;
`ifdef TARGET_PICKER_SEED_LOAD_EN
      seed_load  = 1'b0;
      seed_x_in  = 8'd0;
      seed_y_in  = 7'd0;
      seed2_load = 1'b0;
      seed2_x_in = 8'd0;
      seed2_y_in = 7'd0;
`endif
      test_reset();
      test_fallback();
      test_search();
      test_head_exclusion();
      test_back_to_back();
      test_search();
      test_reset_mid_search();
`ifdef TARGET_PICKER_SEED_LOAD_EN
      test_seed_load();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
